// File: rtl/p2s_pkg.sv
// Shared definitions for the parallel-to-serial scheduler: FSM state encoding
// and default sizing constants used by the top and the arbiter.
package p2s_pkg;

    localparam int unsigned P2S_NUM_REQ = 4;
    localparam int unsigned P2S_DATA_W  = 8;
    localparam int unsigned P2S_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } p2s_state_e;

endpackage : p2s_pkg

// File: rtl/p2s_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first eligible requester searching upward
// from last_grant_i + 1, wrapping modulo NUM_REQ.
//   eligible_i   : per-requester eligibility (valid & mask)
//   last_grant_i : index of the previously granted requester
//   grant_o      : one-hot grant (combinational)
//   index_o      : binary index of the winner (combinational)
//   any_o        : at least one requester eligible (combinational)
module rr_arbiter
    import p2s_pkg::*;
#(
    parameter int unsigned NUM_REQ = P2S_NUM_REQ,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   index_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Scan offsets 1..NUM_REQ so last_grant itself is checked last.
    always_comb begin
        grant_o = '0;
        index_o = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((32'(last_grant_i) + off) % NUM_REQ);
            if (!found && eligible_i[cand]) begin
                found          = 1'b1;
                index_o        = cand;
                grant_o[cand]  = 1'b1;
            end
        end
        any_o = found;
    end

endmodule : rr_arbiter

// File: rtl/p2s_scheduler.sv
// Scheduler sharing one serializer among NUM_REQ byte requesters.
// IDLE grants one eligible requester (round-robin), LOAD strobes the captured
// byte into the serializer, WAIT holds until ser_done or timeout.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/mask    : per-requester byte-available / arbitration enable
//   req_data          : per-requester byte
//   req_ready         : one-hot accept, combinational in IDLE
//   ser_load/data/src : load strobe, captured byte and owner index
//   ser_done          : serializer completion pulse
//   busy, timeout_err : LOAD/WAIT indicator, sticky timeout flag
module p2s_scheduler
    import p2s_pkg::*;
#(
    parameter int unsigned NUM_REQ = P2S_NUM_REQ,
    parameter int unsigned DATA_W  = P2S_DATA_W,
    parameter int unsigned TIMEOUT = P2S_TIMEOUT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]               req_mask,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             ser_load,
    output logic [DATA_W-1:0]                ser_data,
    output logic [$clog2(NUM_REQ)-1:0]       ser_src,
    input  logic                             ser_done,
    output logic                             busy,
    output logic                             timeout_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    p2s_state_e         state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [IDX_W-1:0]   src_q, src_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               terr_q, terr_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .eligible_i   (req_valid & req_mask),
        .last_grant_i (last_q),
        .grant_o      (arb_grant),
        .index_o      (arb_idx),
        .any_o        (arb_any)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            data_q  <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            data_q  <= data_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    // Next-state and handshake logic.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        data_d    = data_q;
        src_d     = src_q;
        cnt_d     = cnt_q;
        terr_d    = terr_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                // No accept while rst is high, so reset never completes a handshake.
                if (arb_any && !rst) begin
                    req_ready = arb_grant;
                    data_d    = req_data[arb_idx];
                    src_d     = arb_idx;
                    last_d    = arb_idx;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // ser_done wins over a coincident timeout expiry.
                if (ser_done) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ser_load    = (state_q == LOAD);
    assign busy        = (state_q != IDLE);
    assign ser_data    = data_q;
    assign ser_src     = src_q;
    assign timeout_err = terr_q;

endmodule : p2s_scheduler

// File: tb/tb_p2s_scheduler.sv
// Self-checking bench for p2s_scheduler (NUM_REQ=4, DATA_W=8, TIMEOUT=64).
module tb_p2s_scheduler;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0][7:0]  req_data;
    logic [3:0]       req_mask;
    logic [3:0]       req_ready;
    logic             ser_load;
    logic [7:0]       ser_data;
    logic [1:0]       ser_src;
    logic             ser_done;
    logic             busy;
    logic             timeout_err;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_last = 3;

    always #5 clk = ~clk;

    p2s_scheduler #(
        .NUM_REQ (4),
        .DATA_W  (8),
        .TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_mask    (req_mask),
        .req_ready   (req_ready),
        .ser_load    (ser_load),
        .ser_data    (ser_data),
        .ser_src     (ser_src),
        .ser_done    (ser_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(logic [3:0] elig, int last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (elig[c]) return c;
        end
        return 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_mask = '1; ser_done = 1'b0; req_data = '0;
        tick();
        tick();
        rst = 1'b0;
        model_last = 3;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({req_ready, ser_load, ser_data, ser_src, busy, timeout_err} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b load=%b data=%h src=%0d busy=%b terr=%b required all zero",
                     req_ready, ser_load, ser_data, ser_src, busy, timeout_err);
        end
    endtask

    task automatic test_single();
        int   w;
        exp_t e;
        do_reset();
        req_valid = 4'b0100; req_data[2] = 8'hA5; #1;
        w = rr_pick(req_valid & req_mask, model_last);
        n_checks++;
        if (req_ready !== 4'(1 << w)) begin
            n_fail++; $display("FAIL single_grant: req_ready=%b required %b", req_ready, 4'(1 << w));
        end
        e.src = 2'(w); e.data = req_data[w]; sb.push_back(e); model_last = w;
        tick();
        req_valid = '0; req_data[2] = 8'h00;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++; $display("FAIL single_load: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if ({ser_load, busy, req_ready, ser_src, ser_data} !== {1'b1, 1'b1, 4'b0000, e.src, e.data}) begin
                n_fail++;
                $display("FAIL single_load: load=%b busy=%b ready=%b src=%0d data=%h required 1 1 0000 %0d %h",
                         ser_load, busy, req_ready, ser_src, ser_data, e.src, e.data);
            end
        end
        tick();
        n_checks++;
        if ({ser_load, busy, ser_data} !== {1'b0, 1'b1, 8'hA5}) begin
            n_fail++; $display("FAIL single_hold: load=%b busy=%b data=%h required 0 1 a5", ser_load, busy, ser_data);
        end
        repeat (3) tick();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        n_checks++;
        if ({busy, ser_src, ser_data} !== {1'b0, 2'd2, 8'hA5}) begin
            n_fail++; $display("FAIL single_done: busy=%b src=%0d data=%h required 0 2 a5", busy, ser_src, ser_data);
        end
    endtask

    task automatic test_fairness();
        int   order[5] = '{0, 1, 2, 3, 0};
        exp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) req_data[i] = 8'($urandom);
        req_valid = '1; req_mask = '1;
        for (int g = 0; g < 5; g++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'(1 << order[g])) begin
                n_fail++; $display("FAIL fair_grant%0d: req_ready=%b required %b", g, req_ready, 4'(1 << order[g]));
            end
            e.src = 2'(order[g]); e.data = req_data[order[g]]; sb.push_back(e);
            tick();
            for (int i = 0; i < 4; i++) req_data[i] = 8'($urandom);
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++; $display("FAIL fair_load%0d: scoreboard empty", g);
            end else begin
                e = sb.pop_front();
                if ({ser_load, ser_src, ser_data} !== {1'b1, e.src, e.data}) begin
                    n_fail++; $display("FAIL fair_load%0d: load=%b src=%0d data=%h required 1 %0d %h",
                                       g, ser_load, ser_src, ser_data, e.src, e.data);
                end
            end
            repeat (8) tick();
            ser_done = 1'b1;
            tick();
            ser_done = 1'b0;
        end
        model_last = 0;
    endtask

    task automatic test_mask();
        int   w;
        int   want[4] = '{1, 3, 1, 3};
        exp_t e;
        do_reset();
        req_valid = '1; req_mask = 4'b1010;
        for (int i = 0; i < 4; i++) req_data[i] = 8'(8'h30 + i);
        for (int g = 0; g < 4; g++) begin
            #1;
            w = rr_pick(req_valid & req_mask, model_last);
            n_checks++;
            if (req_ready !== 4'(1 << want[g]) || req_ready !== 4'(1 << w)) begin
                n_fail++; $display("FAIL mask_grant%0d: req_ready=%b required %b", g, req_ready, 4'(1 << want[g]));
            end
            e.src = 2'(w); e.data = req_data[w]; sb.push_back(e); model_last = w;
            tick();
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++; $display("FAIL mask_load%0d: scoreboard empty", g);
            end else begin
                e = sb.pop_front();
                if ({ser_load, ser_src, ser_data} !== {1'b1, e.src, e.data}) begin
                    n_fail++; $display("FAIL mask_load%0d: load=%b src=%0d data=%h required 1 %0d %h",
                                       g, ser_load, ser_src, ser_data, e.src, e.data);
                end
            end
            repeat (2) tick();
            ser_done = 1'b1;
            tick();
            ser_done = 1'b0;
        end
        req_mask = '1;
    endtask

    task automatic test_timeout();
        int   w;
        exp_t e;
        do_reset();
        req_valid = 4'b0001; req_data[0] = 8'h5C; req_data[1] = 8'hC3; #1;
        w = rr_pick(req_valid & req_mask, model_last);
        n_checks++;
        if (req_ready !== 4'(1 << w)) begin
            n_fail++; $display("FAIL to_grant: req_ready=%b required %b", req_ready, 4'(1 << w));
        end
        e.src = 2'(w); e.data = req_data[w]; sb.push_back(e); model_last = w;
        tick();
        req_valid = '0;
        e = sb.pop_front();
        n_checks++;
        if ({ser_load, ser_src, ser_data} !== {1'b1, e.src, e.data}) begin
            n_fail++; $display("FAIL to_load: load=%b src=%0d data=%h required 1 %0d %h",
                               ser_load, ser_src, ser_data, e.src, e.data);
        end
        tick();
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 63) begin
                n_checks++;
                if ({timeout_err, busy} !== 2'b01) begin
                    n_fail++; $display("FAIL to_early: terr=%b busy=%b required 0 1", timeout_err, busy);
                end
            end
            if (i == 64) begin
                n_checks++;
                if ({timeout_err, busy} !== 2'b10) begin
                    n_fail++; $display("FAIL to_expire: terr=%b busy=%b required 1 0", timeout_err, busy);
                end
            end
        end
        req_valid = 4'b0010; #1;
        w = rr_pick(req_valid & req_mask, model_last);
        n_checks++;
        if (req_ready !== 4'(1 << w)) begin
            n_fail++; $display("FAIL to_regrant: req_ready=%b required %b", req_ready, 4'(1 << w));
        end
        e.src = 2'(w); e.data = req_data[w]; sb.push_back(e); model_last = w;
        tick();
        req_valid = '0;
        e = sb.pop_front();
        n_checks++;
        if ({ser_load, ser_src, ser_data} !== {1'b1, e.src, e.data}) begin
            n_fail++; $display("FAIL to_reload: load=%b src=%0d data=%h required 1 %0d %h",
                               ser_load, ser_src, ser_data, e.src, e.data);
        end
        repeat (2) tick();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        n_checks++;
        if ({timeout_err, busy} !== 2'b10) begin
            n_fail++; $display("FAIL to_sticky: terr=%b busy=%b required 1 0", timeout_err, busy);
        end
    endtask

    task automatic test_reset_mid();
        int   w;
        exp_t e;
        req_valid = '1;
        for (int i = 0; i < 4; i++) req_data[i] = 8'(8'h70 + i);
        #1;
        w = rr_pick(req_valid & req_mask, model_last);
        n_checks++;
        if (req_ready !== 4'(1 << w)) begin
            n_fail++; $display("FAIL rmid_grant: req_ready=%b required %b", req_ready, 4'(1 << w));
        end
        e.src = 2'(w); e.data = req_data[w]; sb.push_back(e); model_last = w;
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({ser_load, ser_src, ser_data} !== {1'b1, e.src, e.data}) begin
            n_fail++; $display("FAIL rmid_load: load=%b src=%0d data=%h required 1 %0d %h",
                               ser_load, ser_src, ser_data, e.src, e.data);
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({req_ready, ser_load, busy, timeout_err, ser_src, ser_data} !== 18'd0) begin
            n_fail++; $display("FAIL rmid_in_reset: ready=%b load=%b busy=%b terr=%b src=%0d data=%h required all zero",
                               req_ready, ser_load, busy, timeout_err, ser_src, ser_data);
        end
        rst = 1'b0;
        model_last = 3;
        #1;
        w = rr_pick(req_valid & req_mask, model_last);
        n_checks++;
        if (req_ready !== 4'b0001 || req_ready !== 4'(1 << w)) begin
            n_fail++; $display("FAIL rmid_first: req_ready=%b required 0001", req_ready);
        end
        e.src = 2'(w); e.data = req_data[w]; sb.push_back(e); model_last = w;
        tick();
        req_valid = '0;
        e = sb.pop_front();
        n_checks++;
        if ({ser_load, ser_src, ser_data} !== {1'b1, e.src, e.data}) begin
            n_fail++; $display("FAIL rmid_reload: load=%b src=%0d data=%h required 1 %0d %h",
                               ser_load, ser_src, ser_data, e.src, e.data);
        end
        repeat (2) tick();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
    endtask

    task automatic test_stray_done();
        exp_t e;
        do_reset();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        n_checks++;
        if ({busy, ser_load, req_ready, timeout_err} !== 7'd0) begin
            n_fail++; $display("FAIL stray_idle: busy=%b load=%b ready=%b terr=%b required all zero",
                               busy, ser_load, req_ready, timeout_err);
        end
        req_valid = 4'b0001; req_data[0] = 8'h3E; #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL stray_grant: req_ready=%b required 0001", req_ready);
        end
        e.src = 2'd0; e.data = req_data[0]; sb.push_back(e);
        tick();
        req_valid = '0;
        e = sb.pop_front();
        n_checks++;
        if ({ser_load, ser_src, ser_data} !== {1'b1, e.src, e.data}) begin
            n_fail++; $display("FAIL stray_load: load=%b src=%0d data=%h required 1 %0d %h",
                               ser_load, ser_src, ser_data, e.src, e.data);
        end
        tick();
        repeat (63) tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL coinc_pre: busy=%b required 1", busy);
        end
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        n_checks++;
        if ({timeout_err, busy} !== 2'b00) begin
            n_fail++; $display("FAIL coinc_done: terr=%b busy=%b required 0 0", timeout_err, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_mask();
        test_timeout();
        test_reset_mid();
        test_stray_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule : tb_p2s_scheduler
